cmd_mem_reader: RTL and testbench

Read side of the command register memory: scans the 256-entry command memory, finds commands whose `TIME_START` has been reached by system time, and clears their slots through the writer. It then hands each command's fields to the synchronisation/execution block over a valid/ack handshake. It sits between the command memory read port, the memory writer's clear path, and the executor, and reports the count of pending commands per scan.

---
 rtl/cmd_mem_reader_if.sv | 34 +++
 rtl/cmd_mem_reader.sv | 87 ++++++++
 tb/tb_cmd_mem_reader.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_mem_reader_if.sv
// cmd_mem_reader_if: memory read port, writer clear path and executor dispatch bundle
interface cmd_mem_reader_if;
  logic         RD_EN;
  logic [7:0]   RD_ADDR;
  logic [337:0] RD_DATA;
  logic         CLR_REQ;
  logic [7:0]   CLR_ADDR;
  logic         CLR_ACK;
  logic         CMD_VALID;
  logic         CMD_ACK;
  logic [63:0]  TIME_START_z;
  logic [47:0]  FREQ_z;
  logic [47:0]  FREQ_STEP_z;
  logic [31:0]  FREQ_RATE_z;
  logic [15:0]  N_impuls_z;
  logic [1:0]   TYPE_impulse_z;
  logic [31:0]  Interval_Ti_z;
  logic [31:0]  Interval_Tp_z;
  logic [31:0]  Tblank1_z;
  logic [31:0]  Tblank2_z;
  logic         CMD_LATE;
  modport master (
    output RD_EN, RD_ADDR, CLR_REQ, CLR_ADDR, CMD_VALID, CMD_LATE,
           TIME_START_z, FREQ_z, FREQ_STEP_z, FREQ_RATE_z, N_impuls_z, TYPE_impulse_z,
           Interval_Ti_z, Interval_Tp_z, Tblank1_z, Tblank2_z,
    input  RD_DATA, CLR_ACK, CMD_ACK
  );
  modport slave (
    input  RD_EN, RD_ADDR, CLR_REQ, CLR_ADDR, CMD_VALID, CMD_LATE,
           TIME_START_z, FREQ_z, FREQ_STEP_z, FREQ_RATE_z, N_impuls_z, TYPE_impulse_z,
           Interval_Ti_z, Interval_Tp_z, Tblank1_z, Tblank2_z,
    output RD_DATA, CLR_ACK, CMD_ACK
  );
endinterface

// File: rtl/cmd_mem_reader.sv
// cmd_mem_reader: scans command memory, clears and dispatches due commands in address order
module cmd_mem_reader #(
  parameter logic [7:0]  N_IDX   = 8'd255,
  parameter logic [63:0] LATE_TH = 64'd0
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  EN,
  input  logic [63:0]           TIME_NOW,
  cmd_mem_reader_if.master      bus,
  output logic [8:0]            N_PEND,
  output logic                  BUSY
);
  typedef enum logic [2:0] {IDLE, RD, CHK, CLR, DISP} state_t;
  state_t      state, state_n;
  logic [7:0]  addr, addr_n;
  logic [8:0]  pend_cnt, pend_n, n_pend_n;
  logic [63:0] ts;
  logic        free, due, load, adv;
  assign ts   = bus.RD_DATA[337:274];
  assign free = &ts;
  assign due  = !free && ts <= TIME_NOW;
  assign bus.RD_ADDR  = addr;
  assign bus.CLR_ADDR = addr;
  always_comb begin
    state_n  = state;
    addr_n   = addr;
    pend_n   = pend_cnt;
    n_pend_n = N_PEND;
    load     = 1'b0;
    adv      = 1'b0;
    case (state)
      IDLE: state_n = EN ? RD : IDLE;
      RD:   state_n = CHK;
      CHK: begin
        load    = due;
        adv     = !due;
        pend_n  = pend_cnt + 9'(!free && !due);
        state_n = due ? CLR : CHK;
      end
      CLR:  state_n = bus.CLR_ACK ? DISP : CLR;
      DISP: adv = bus.CMD_ACK;
      default: state_n = IDLE;
    endcase
    // the last entry closes the scan and publishes its pending count
    if (adv && addr == N_IDX) begin
      state_n  = IDLE;
      addr_n   = '0;
      n_pend_n = pend_n;
      pend_n   = '0;
    end else if (adv) begin
      state_n = RD;
      addr_n  = addr + 8'd1;
    end
  end
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      addr          <= '0;
      pend_cnt      <= '0;
      N_PEND        <= '0;
      BUSY          <= 1'b0;
      bus.RD_EN     <= 1'b0;
      bus.CLR_REQ   <= 1'b0;
      bus.CMD_VALID <= 1'b0;
      bus.CMD_LATE  <= 1'b0;
      {bus.TIME_START_z, bus.FREQ_z, bus.FREQ_STEP_z, bus.FREQ_RATE_z, bus.N_impuls_z,
       bus.TYPE_impulse_z, bus.Interval_Ti_z, bus.Interval_Tp_z, bus.Tblank1_z,
       bus.Tblank2_z} <= '0;
    end else begin
      state         <= state_n;
      addr          <= addr_n;
      pend_cnt      <= pend_n;
      N_PEND        <= n_pend_n;
      BUSY          <= state_n != IDLE;
      bus.RD_EN     <= state_n == RD;
      bus.CLR_REQ   <= state_n == CLR;
      bus.CMD_VALID <= state_n == DISP;
      if (load) begin
        bus.CMD_LATE <= (TIME_NOW - ts) > LATE_TH;
        {bus.TIME_START_z, bus.FREQ_z, bus.FREQ_STEP_z, bus.FREQ_RATE_z, bus.N_impuls_z,
         bus.TYPE_impulse_z, bus.Interval_Ti_z, bus.Interval_Tp_z, bus.Tblank1_z,
         bus.Tblank2_z} <= bus.RD_DATA;
      end
    end
  end
endmodule

// File: tb/tb_cmd_mem_reader.sv
// tb_cmd_mem_reader: randomized scoreboard bench with memory, writer and executor models
module tb_cmd_mem_reader;
  localparam logic [63:0] LTH = 64'd1000;
  logic        CLK = 1'b0, rst = 1'b1, EN = 1'b0;
  logic [63:0] TIME_NOW = '0;
  logic [8:0]  N_PEND;
  logic        BUSY;
  cmd_mem_reader_if bus();
  cmd_mem_reader #(.N_IDX(8'd255), .LATE_TH(LTH)) dut (
    .CLK(CLK), .rst(rst), .EN(EN), .TIME_NOW(TIME_NOW), .bus(bus), .N_PEND(N_PEND), .BUSY(BUSY));
  always #5 CLK = ~CLK;
  typedef struct {
    logic [7:0]   addr;
    logic [337:0] data;
    logic         late;
  } item_t;
  item_t        q[$];
  item_t        cur;
  logic         have = 1'b0, pv = 1'b0, pc = 1'b0, stray = 1'b0;
  logic [337:0] mem [256];
  logic [337:0] fz;
  logic [7:0]   ra;
  logic [8:0]   exp_pend = '0;
  int           checks = 0, passes = 0;
  int           clr_lo = 0, clr_hi = 3, cmd_lo = 0, cmd_hi = 3, cd, md;
  assign fz = {bus.TIME_START_z, bus.FREQ_z, bus.FREQ_STEP_z, bus.FREQ_RATE_z, bus.N_impuls_z,
               bus.TYPE_impulse_z, bus.Interval_Ti_z, bus.Interval_Tp_z, bus.Tblank1_z, bus.Tblank2_z};

  task automatic chk(string name, logic [337:0] act, logic [337:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [337:0] rnd_cmd(logic [63:0] ts);
    logic [337:0] r = '0;
    for (int i = 0; i < 11; i++) r = {r[305:0], 32'($urandom)};
    r[337:274] = ts;
    return r;
  endfunction

  task automatic clear_mem();
    for (int a = 0; a < 256; a++) mem[a] = rnd_cmd('1);
  endtask

  // reference: every occupied slot is either due (dispatched in address order) or pending
  task automatic model(logic [63:0] now);
    logic [63:0] ts;
    exp_pend = '0;
    TIME_NOW = now;
    for (int a = 0; a < 256; a++) begin
      ts = mem[a][337:274];
      if (ts != '1) begin
        if (ts <= now) q.push_back('{addr: 8'(a), data: mem[a], late: (now - ts) > LTH});
        else exp_pend++;
      end
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (BUSY && n < 6000) begin
      @(negedge CLK);
      n++;
    end
    chk("scan_completes", BUSY, 0);
    chk("n_pend", N_PEND, exp_pend);
    chk("all_dispatched", q.size(), 0);
  endtask

  task automatic run_scan(logic [63:0] now);
    model(now);
    @(negedge CLK); EN = 1'b1;
    @(negedge CLK); EN = 1'b0;
    wait_idle();
  endtask

  task automatic fill_random(logic [63:0] now);
    for (int a = 0; a < 256; a++)
      mem[a] = $urandom_range(0, 1) ? rnd_cmd('1) : rnd_cmd(now + 64'($urandom_range(0, 4000)) - 64'd2000);
  endtask

  // memory with one cycle read latency
  initial begin
    bus.RD_DATA = '1;
    forever begin
      @(posedge CLK);
      if (bus.RD_EN) begin
        ra = bus.RD_ADDR;
        #1 bus.RD_DATA = mem[ra];
      end
    end
  end

  // writer: acknowledges clears after a random delay and frees the slot
  initial begin
    bus.CLR_ACK = 1'b0;
    forever begin
      @(negedge CLK);
      if (stray) begin
        bus.CLR_ACK = 1'b1;
        @(negedge CLK); bus.CLR_ACK = 1'b0;
      end else if (bus.CLR_REQ && !rst) begin
        cd = $urandom_range(clr_hi, clr_lo);
        for (int i = 0; i < cd && !rst; i++) @(negedge CLK);
        if (!rst) begin
          bus.CLR_ACK = 1'b1;
          mem[bus.CLR_ADDR][337:274] = '1;
          @(negedge CLK); bus.CLR_ACK = 1'b0;
        end
      end
    end
  end

  // executor: accepts commands after a random delay
  initial begin
    bus.CMD_ACK = 1'b0;
    forever begin
      @(negedge CLK);
      if (stray) begin
        bus.CMD_ACK = 1'b1;
        @(negedge CLK); bus.CMD_ACK = 1'b0;
      end else if (bus.CMD_VALID && !rst) begin
        md = $urandom_range(cmd_hi, cmd_lo);
        for (int i = 0; i < md && !rst; i++) @(negedge CLK);
        if (!rst) begin
          bus.CMD_ACK = 1'b1;
          @(negedge CLK); bus.CMD_ACK = 1'b0;
        end
      end
    end
  end

  // monitor: pops the scoreboard as clears and dispatches appear
  initial forever begin
    @(posedge CLK); #1;
    if (rst) begin
      pv = 1'b0; pc = 1'b0; have = 1'b0;
    end else begin
      if (bus.CLR_REQ || bus.CMD_VALID) chk("clr_disp_exclusive", bus.CLR_REQ & bus.CMD_VALID, 0);
      if (bus.CLR_REQ && !pc) begin
        if (q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_clr: CLR_ADDR=%0d, no due slot expected", bus.CLR_ADDR);
        end else chk("clr_addr", bus.CLR_ADDR, q[0].addr);
      end
      if (bus.CMD_VALID && !pv) begin
        if (q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_dispatch: TIME_START_z=%0d, no due slot expected", bus.TIME_START_z);
          have = 1'b0;
        end else begin
          cur = q.pop_front();
          have = 1'b1;
        end
      end
      if (bus.CMD_VALID && have) begin
        chk("cmd_fields", fz, cur.data);
        chk("cmd_late", bus.CMD_LATE, cur.late);
      end
      if (!bus.CMD_VALID && pv && have) chk("fields_held", fz, cur.data);
      pv = bus.CMD_VALID;
      pc = bus.CLR_REQ;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nstart, last, n;
    logic [63:0] now;
    clear_mem();
    repeat (3) @(negedge CLK);
    chk("rst_rd_en", bus.RD_EN, 0);
    chk("rst_clr_req", bus.CLR_REQ, 0);
    chk("rst_cmd_valid", bus.CMD_VALID, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_n_pend", N_PEND, 0);
    chk("rst_rd_addr", bus.RD_ADDR, 0);
    chk("rst_clr_addr", bus.CLR_ADDR, 0);
    chk("rst_fields", fz, 0);
    chk("rst_late", bus.CMD_LATE, 0);
    rst = 1'b0;
    // all-free memory with EN held: periodic scans, nothing dispatched
    @(negedge CLK); EN = 1'b1; TIME_NOW = 64'd0;
    nstart = 0; last = 0;
    for (int c = 0; c < 1100; c++) begin
      @(posedge CLK); #1;
      if (bus.RD_EN && bus.RD_ADDR == 8'd0) begin
        if (nstart > 0) chk("scan_period", c - last, 513);
        last = c;
        nstart++;
      end
    end
    chk("scan_starts", nstart, 3);
    @(negedge CLK); EN = 1'b0;
    exp_pend = '0;
    wait_idle();
    // single slot: pending first, then due
    mem[5] = rnd_cmd(64'd100);
    run_scan(64'd50);
    run_scan(64'd100);
    chk("t2_late", bus.CMD_LATE, 0);
    chk("t2_time_start", bus.TIME_START_z, 100);
    // two due slots with a slow executor
    clear_mem();
    mem[3] = rnd_cmd(64'd20);
    mem[200] = rnd_cmd(64'd30);
    cmd_lo = 10; cmd_hi = 10;
    run_scan(64'd40);
    cmd_lo = 0; cmd_hi = 3;
    chk("t3_last_dispatch", bus.TIME_START_z, 30);
    // lateness threshold on both sides
    clear_mem();
    mem[9] = rnd_cmd(64'd10);
    run_scan(64'd2000);
    chk("late_over_th", bus.CMD_LATE, 1);
    mem[9] = rnd_cmd(64'd10);
    run_scan(64'd1010);
    chk("late_at_th", bus.CMD_LATE, 0);
    // randomized memory contents and ack delays
    for (int it = 0; it < 4; it++) begin
      now = 64'd5000 + 64'($urandom_range(0, 100000));
      fill_random(now);
      run_scan(now);
    end
    // asynchronous reset during a dispatch
    clear_mem();
    mem[50] = rnd_cmd(64'd1);
    cmd_lo = 1000; cmd_hi = 1000;
    model(64'd10);
    @(negedge CLK); EN = 1'b1;
    @(negedge CLK); EN = 1'b0;
    n = 0;
    while (!bus.CMD_VALID && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    chk("valid_before_reset", bus.CMD_VALID, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", bus.CMD_VALID, 0);
    chk("async_rst_busy", BUSY, 0);
    q.delete();
    cmd_lo = 0; cmd_hi = 3;
    @(negedge CLK); rst = 1'b0;
    model(64'd10);
    EN = 1'b1;
    n = 0;
    while (!bus.RD_EN && n < 100) begin
      @(negedge CLK);
      n++;
    end
    chk("rd_after_reset", bus.RD_EN, 1);
    chk("first_addr_after_reset", bus.RD_ADDR, 0);
    EN = 1'b0;
    wait_idle();
    // EN dropped mid-scan: scan completes, then ignores stray acks
    now = 64'd70000;
    fill_random(now);
    model(now);
    @(negedge CLK); EN = 1'b1;
    n = 0;
    while (!(bus.RD_EN && bus.RD_ADDR == 8'd100) && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    chk("reached_addr_100", bus.RD_ADDR, 100);
    EN = 1'b0;
    wait_idle();
    @(posedge CLK); stray = 1'b1;
    @(posedge CLK); stray = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      chk("idle_ignores_acks", {BUSY, bus.RD_EN, bus.CLR_REQ, bus.CMD_VALID}, 0);
    end
    chk("n_pend_held", N_PEND, exp_pend);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
